// File: rtl/refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : refill_arbiter
// Brief    : Round-robin arbiter sharing one line-refill read port between
//            the icache and dcache; steers returning beats to the winner.
// Revision : 1.0
// ============================================================================
module refill_arbiter #(
    parameter int BEATS_PER_LINE = 8,
    parameter int OFFSET_W       = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ic_req,
    input  logic [63:0]                       ic_addr,
    output logic                              ic_gnt,
    output logic                              ic_beat_valid,
    output logic                              ic_done,
    input  logic                              dc_req,
    input  logic [63:0]                       dc_addr,
    output logic                              dc_gnt,
    output logic                              dc_beat_valid,
    output logic                              dc_done,
    output logic [63:0]                       beat_data,
    output logic [$clog2(BEATS_PER_LINE)-1:0] beat_idx,
    output logic                              mem_req,
    output logic [63:0]                       mem_addr,
    input  logic                              mem_ack,
    input  logic                              mem_beat_valid,
    input  logic [63:0]                       mem_data,
    input  logic                              mem_last,
    output logic                              err
);

    localparam int               IDX_W     = $clog2(BEATS_PER_LINE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEATS_PER_LINE - 1);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
    localparam logic [63:0]      ADDR_MASK = ~((64'd1 << OFFSET_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_next;
    logic               gnt_ic, gnt_ic_next;
    logic               gnt_dc, gnt_dc_next;
    logic [63:0]        addr, addr_next;
    logic [IDX_W-1:0]   cnt, cnt_next;
    logic               last_dc, last_dc_next;
    logic               err_q, err_next;
    logic               pick_dc;

    // On a tie the requester that did not win the previous line gets the port.
    assign pick_dc = dc_req && (!ic_req || !last_dc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt_ic  <= 1'b0;
            gnt_dc  <= 1'b0;
            addr    <= '0;
            cnt     <= '0;
            last_dc <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            gnt_ic  <= gnt_ic_next;
            gnt_dc  <= gnt_dc_next;
            addr    <= addr_next;
            cnt     <= cnt_next;
            last_dc <= last_dc_next;
            err_q   <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        gnt_ic_next  = gnt_ic;
        gnt_dc_next  = gnt_dc;
        addr_next    = addr;
        cnt_next     = cnt;
        last_dc_next = last_dc;
        err_next     = err_q;
        case (state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    gnt_ic_next = !pick_dc;
                    gnt_dc_next = pick_dc;
                    addr_next   = (pick_dc ? dc_addr : ic_addr) & ADDR_MASK;
                    cnt_next    = '0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (mem_beat_valid) begin
                    cnt_next = cnt + ONE_IDX;
                    if (cnt == LAST_IDX) begin
                        state_next = DONE;
                        if (!mem_last) begin
                            err_next = 1'b1;
                        end
                    end else if (mem_last) begin
                        // Short burst: close the line early and flag it.
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                last_dc_next = gnt_dc;
                gnt_ic_next  = 1'b0;
                gnt_dc_next  = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ic_gnt        = gnt_ic;
    assign dc_gnt        = gnt_dc;
    assign mem_req       = (state == REQ);
    assign mem_addr      = addr;
    assign err           = err_q;
    assign beat_data     = mem_data;
    assign beat_idx      = cnt;
    assign ic_beat_valid = (state == DATA) && mem_beat_valid && gnt_ic;
    assign dc_beat_valid = (state == DATA) && mem_beat_valid && gnt_dc;
    assign ic_done       = (state == DONE) && gnt_ic;
    assign dc_done       = (state == DONE) && gnt_dc;

endmodule
`default_nettype wire

// File: tb/tb_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_refill_arbiter
// Brief    : Directed self-checking bench for refill_arbiter.
// Revision : 1.0
// ============================================================================
module tb_refill_arbiter;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, ic_gnt, ic_beat_valid, ic_done;
    logic        dc_req, dc_gnt, dc_beat_valid, dc_done;
    logic [63:0] ic_addr, dc_addr;
    logic [63:0] beat_data;
    logic [2:0]  beat_idx;
    logic        mem_req, mem_ack, mem_beat_valid, mem_last, err;
    logic [63:0] mem_addr, mem_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    refill_arbiter #(
        .BEATS_PER_LINE (BEATS),
        .OFFSET_W       (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_gnt         (ic_gnt),
        .ic_beat_valid  (ic_beat_valid),
        .ic_done        (ic_done),
        .dc_req         (dc_req),
        .dc_addr        (dc_addr),
        .dc_gnt         (dc_gnt),
        .dc_beat_valid  (dc_beat_valid),
        .dc_done        (dc_done),
        .beat_data      (beat_data),
        .beat_idx       (beat_idx),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_beat_valid (mem_beat_valid),
        .mem_data       (mem_data),
        .mem_last       (mem_last),
        .err            (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b0;
        mem_beat_valid = 1'b0; mem_last = 1'b0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    // Single-requester line; returns in the DONE cycle when the line completes.
    task automatic drive_line(input bit use_dc, input logic [63:0] addr,
                              input int nbeats, input int last_at);
        if (use_dc) begin dc_req = 1'b1; dc_addr = addr; end
        else begin ic_req = 1'b1; ic_addr = addr; end
        tick;
        ic_req = 1'b0; dc_req = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            mem_beat_valid = 1'b1;
            mem_data = 64'h1111_0000_0000_0000 + 64'(i);
            mem_last = (i == last_at);
            tick;
        end
        mem_beat_valid = 1'b0;
        mem_last = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
        ic_addr = 64'h1234; dc_addr = 64'h5678;
        mem_ack = 1'b1; mem_beat_valid = 1'b1; mem_last = 1'b1; mem_data = 64'hFFFF;
        tick;
        checks++;
        if ({ic_gnt, dc_gnt, mem_req, ic_done, dc_done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {ic_gnt, dc_gnt, mem_req, ic_done, dc_done, err});
        end
        checks++;
        if (mem_addr !== 64'h0 || beat_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_addr_idx: got addr=%h idx=%0d expected 0/0", mem_addr, beat_idx);
        end
        checks++;
        if ({ic_beat_valid, dc_beat_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_beat_valid: got %b expected 00", {ic_beat_valid, dc_beat_valid});
        end
        ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b0;
        mem_beat_valid = 1'b0; mem_last = 1'b0;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_single_ic;
        ic_req = 1'b1; ic_addr = 64'h0000_0000_8000_1234;
        tick;
        ic_req = 1'b0;
        #2;
        checks++;
        if (ic_gnt !== 1'b1 || dc_gnt !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got ic_gnt=%b dc_gnt=%b mem_req=%b expected 1 0 1",
                     ic_gnt, dc_gnt, mem_req);
        end
        checks++;
        if (mem_addr !== 64'h0000_0000_8000_1200) begin
            errors++;
            $display("FAIL single_addr: got %h expected 0000000080001200", mem_addr);
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        #2;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_drop: got mem_req=%b expected 0", mem_req);
        end
        for (int i = 0; i < BEATS; i++) begin
            mem_beat_valid = 1'b1;
            mem_data = 64'hA5A5_0000_0000_0000 + 64'(i);
            mem_last = (i == BEATS - 1);
            #2;
            checks++;
            if (ic_beat_valid !== 1'b1 || dc_beat_valid !== 1'b0 || beat_idx !== 3'(i) ||
                beat_data !== (64'hA5A5_0000_0000_0000 + 64'(i))) begin
                errors++;
                $display("FAIL single_beat%0d: got icv=%b dcv=%b idx=%0d data=%h expected 1 0 %0d %h",
                         i, ic_beat_valid, dc_beat_valid, beat_idx, beat_data, i,
                         64'hA5A5_0000_0000_0000 + 64'(i));
            end
            tick;
        end
        mem_beat_valid = 1'b0; mem_last = 1'b0;
        #2;
        checks++;
        if (ic_done !== 1'b1 || ic_gnt !== 1'b1 || dc_done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got ic_done=%b ic_gnt=%b dc_done=%b err=%b expected 1 1 0 0",
                     ic_done, ic_gnt, dc_done, err);
        end
        tick;
        checks++;
        if (ic_done !== 1'b0 || ic_gnt !== 1'b0) begin
            errors++;
            $display("FAIL single_after_done: got ic_done=%b ic_gnt=%b expected 0 0", ic_done, ic_gnt);
        end
    endtask

    task automatic test_alternation;
        bit exp_dc;
        do_reset;
        ic_req = 1'b1; dc_req = 1'b1;
        ic_addr = 64'h0000_0000_1000_0047;
        dc_addr = 64'h0000_0000_2000_00BF;
        exp_dc = 1'b1;
        for (int line = 0; line < 6; line++) begin
            int w;
            w = 0;
            while (!(ic_gnt || dc_gnt) && w < 10) begin
                tick;
                w++;
            end
            checks++;
            if (w >= 10) begin
                errors++;
                $display("FAIL alt_grant_timeout line%0d: got no grant expected grant within 10 cycles", line);
            end
            checks++;
            if (ic_gnt !== !exp_dc || dc_gnt !== exp_dc) begin
                errors++;
                $display("FAIL alt_grant line%0d: got ic=%b dc=%b expected ic=%b dc=%b",
                         line, ic_gnt, dc_gnt, !exp_dc, exp_dc);
            end
            checks++;
            if (mem_addr !== (exp_dc ? 64'h0000_0000_2000_0080 : 64'h0000_0000_1000_0040)) begin
                errors++;
                $display("FAIL alt_addr line%0d: got %h expected %h", line, mem_addr,
                         exp_dc ? 64'h0000_0000_2000_0080 : 64'h0000_0000_1000_0040);
            end
            mem_ack = 1'b1;
            tick;
            mem_ack = 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                mem_beat_valid = 1'b1;
                mem_data = 64'(line * 16 + i);
                mem_last = (i == BEATS - 1);
                #2;
                checks++;
                if ((ic_gnt && dc_gnt) || dc_beat_valid !== exp_dc || ic_beat_valid !== !exp_dc) begin
                    errors++;
                    $display("FAIL alt_beat line%0d beat%0d: got gnt=%b%b icv=%b dcv=%b expected dcv=%b",
                             line, i, ic_gnt, dc_gnt, ic_beat_valid, dc_beat_valid, exp_dc);
                end
                tick;
            end
            mem_beat_valid = 1'b0; mem_last = 1'b0;
            #2;
            checks++;
            if (dc_done !== exp_dc || ic_done !== !exp_dc) begin
                errors++;
                $display("FAIL alt_done line%0d: got ic_done=%b dc_done=%b expected dc_done=%b",
                         line, ic_done, dc_done, exp_dc);
            end
            tick;
            exp_dc = !exp_dc;
        end
        ic_req = 1'b0; dc_req = 1'b0;
        tick;
    endtask

    task automatic test_wait_states;
        int gaps[8] = '{2, 0, 1, 3, 0, 0, 1, 2};
        int count;
        bit idx_bad;
        bit early_done;
        count = 0; idx_bad = 1'b0; early_done = 1'b0;
        ic_req = 1'b1; ic_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        ic_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin
                errors++;
                $display("FAIL wait_req_hold cycle%0d: got req=%b addr=%h expected 1 ffffffffffffffc0",
                         c, mem_req, mem_addr);
            end
            tick;
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        #2;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_req_drop: got mem_req=%b expected 0", mem_req);
        end
        for (int i = 0; i < BEATS; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                mem_beat_valid = 1'b0; mem_last = 1'b0; mem_data = 64'hDEAD_BEEF;
                #2;
                if (ic_beat_valid) count++;
                if (ic_done) early_done = 1'b1;
                tick;
            end
            mem_beat_valid = 1'b1; mem_last = (i == BEATS - 1);
            mem_data = 64'h7700 + 64'(i);
            #2;
            if (ic_beat_valid) count++;
            if (beat_idx !== 3'(i)) idx_bad = 1'b1;
            if (ic_done) early_done = 1'b1;
            tick;
        end
        mem_beat_valid = 1'b0; mem_last = 1'b0;
        #2;
        checks++;
        if (count != BEATS || idx_bad) begin
            errors++;
            $display("FAIL wait_beat_count: got count=%0d idx_bad=%b expected 8 0", count, idx_bad);
        end
        checks++;
        if (ic_done !== 1'b1 || early_done) begin
            errors++;
            $display("FAIL wait_done: got ic_done=%b early=%b expected 1 0", ic_done, early_done);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL wait_err: got %b expected 0", err);
        end
        tick;
    endtask

    task automatic test_protocol_errors;
        do_reset;
        drive_line(1'b1, 64'h0000_0000_0000_3FC0, 5, 4);
        #2;
        checks++;
        if (dc_done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL short_line: got dc_done=%b err=%b expected 1 1", dc_done, err);
        end
        tick;
        checks++;
        if (ic_gnt !== 1'b0 || dc_gnt !== 1'b0 || dc_done !== 1'b0) begin
            errors++;
            $display("FAIL short_line_idle: got gnt=%b%b done=%b expected 00 0", ic_gnt, dc_gnt, dc_done);
        end
        do_reset;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %b expected 0", err);
        end
        drive_line(1'b1, 64'h0000_0000_0000_4000, BEATS, -1);
        #2;
        checks++;
        if (dc_done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL missing_last: got dc_done=%b err=%b expected 1 1", dc_done, err);
        end
        tick;
        drive_line(1'b0, 64'h0000_0000_0000_5000, BEATS, BEATS - 1);
        #2;
        checks++;
        if (ic_done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got ic_done=%b err=%b expected 1 1", ic_done, err);
        end
        tick;
    endtask

    task automatic test_reset_mid_data;
        do_reset;
        drive_line(1'b0, 64'h0000_0000_0000_0040, 4, -1);
        mem_beat_valid = 1'b1; mem_data = 64'h5555;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({ic_gnt, dc_gnt, mem_req, ic_done, dc_done, err, ic_beat_valid, dc_beat_valid} !== 8'b0 ||
            mem_addr !== 64'h0 || beat_idx !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ctrl=%b addr=%h idx=%0d expected all 0",
                     {ic_gnt, dc_gnt, mem_req, ic_done, dc_done, err, ic_beat_valid, dc_beat_valid},
                     mem_addr, beat_idx);
        end
        tick;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            mem_beat_valid = 1'b1; mem_last = 1'b1; mem_data = 64'h9900 + 64'(s);
            #2;
            checks++;
            if ({ic_beat_valid, dc_beat_valid, ic_gnt, dc_gnt, mem_req} !== 5'b0) begin
                errors++;
                $display("FAIL stray_beat%0d: got v=%b%b gnt=%b%b req=%b expected all 0",
                         s, ic_beat_valid, dc_beat_valid, ic_gnt, dc_gnt, mem_req);
            end
            tick;
        end
        mem_beat_valid = 1'b0; mem_last = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL stray_err: got %b expected 0", err);
        end
        ic_req = 1'b1; ic_addr = 64'h0000_0000_0000_0080;
        tick;
        ic_req = 1'b0;
        #2;
        checks++;
        if (ic_gnt !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got ic_gnt=%b mem_req=%b expected 1 1", ic_gnt, mem_req);
        end
        do_reset;
    endtask

    task automatic test_withdrawal;
        int count;
        count = 0;
        ic_req = 1'b1; ic_addr = 64'h1234_5678_9ABC_DEF0;
        tick;
        ic_req = 1'b0;
        tick;
        tick;
        #2;
        checks++;
        if (ic_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 64'h1234_5678_9ABC_DEC0) begin
            errors++;
            $display("FAIL withdraw_req: got gnt=%b req=%b addr=%h expected 1 1 123456789abcdec0",
                     ic_gnt, mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            mem_beat_valid = 1'b1; mem_last = (i == BEATS - 1);
            mem_data = 64'hBB00 + 64'(i);
            #2;
            if (ic_beat_valid) count++;
            tick;
        end
        mem_beat_valid = 1'b0; mem_last = 1'b0;
        #2;
        checks++;
        if (count != BEATS || ic_done !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_complete: got beats=%0d ic_done=%b expected 8 1", count, ic_done);
        end
        tick;
    endtask

    initial begin
        ic_req = 1'b0; dc_req = 1'b0; ic_addr = '0; dc_addr = '0;
        mem_ack = 1'b0; mem_beat_valid = 1'b0; mem_data = '0; mem_last = 1'b0;
        rst = 1'b0;
        test_reset;
        test_single_ic;
        test_alternation;
        test_wait_states;
        test_protocol_errors;
        test_reset_mid_data;
        test_withdrawal;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/refill_arbiter.md
# refill_arbiter

Shares the single AXI read refill port between the instruction cache and the data cache. Each cache raises a line-refill request with a miss address. The arbiter picks one requester per transaction using round-robin, then issues one line-aligned read to memory. It steers the returning 64-bit beats to the granted cache and signals completion. It sits between the two cache controllers and the AXI read master, and owns the only path to memory for line fills.

## Interface
Parameters:
- BEATS_PER_LINE, 8, number of 64-bit beats per cache line (64-byte line); power of two
- OFFSET_W, 6, number of line-offset address bits cleared when forming the memory address

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ic_req  in  1  icache refill request; level, sampled only in IDLE
- ic_addr  in  64  icache miss address; latched at grant
- ic_gnt  out  1  icache owns the port; high from grant through DONE
- ic_beat_valid  out  1  beat on beat_data belongs to icache
- ic_done  out  1  one-cycle pulse: icache line complete
- dc_req, dc_addr, dc_gnt, dc_beat_valid, dc_done  same widths and meaning for the dcache
- beat_data  out  64  shared refill data, equal to mem_data
- beat_idx  out  log2(BEATS_PER_LINE)  index of the current beat within the line
- mem_req  out  1  memory read request; held until mem_ack
- mem_addr  out  64  line-aligned read address (low OFFSET_W bits zero)
- mem_ack  in  1  memory accepted the address (handshake completes when mem_req & mem_ack)
- mem_beat_valid  in  1  one data beat present on mem_data
- mem_data  in  64  read data beat
- mem_last  in  1  marks the final beat of the burst
- err  out  1  sticky protocol error flag

## Operation
- States: IDLE, REQ, DATA, DONE.
- IDLE
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that was not granted last.
  - last_grant resets to icache, so the first tie goes to the dcache.
  - On grant:
    - Latch addr with bits [OFFSET_W-1:0] cleared into mem_addr.
    - Set xx_gnt and mem_req.
    - Clear the beat counter.
    - Go to REQ.
- REQ
  - Hold mem_req and mem_addr stable.
  - On mem_ack, deassert mem_req next cycle and go to DATA.
- DATA
  - beat_data, beat_idx and xx_beat_valid are combinational from mem_data, the beat counter, and mem_beat_valid & xx_gnt.
  - The counter increments on each mem_beat_valid.
  - If the counter equals BEATS_PER_LINE-1 and mem_beat_valid is high: go to DONE. If mem_last is low at that beat, set err.
  - If mem_last arrives with the counter below BEATS_PER_LINE-1: set err and go to DONE (short line).
  - Beats with mem_beat_valid low are ignored; wait states are unbounded.
- DONE
  - Pulse xx_done for one cycle; xx_gnt stays high in this cycle.
  - Record last_grant.
  - Return to IDLE; xx_gnt drops.
- Requests
  - A requester deasserting req during REQ or DATA is ignored; the transfer completes normally.
  - A req still high in the IDLE after DONE is treated as a new request.
- The grant is one-hot: ic_gnt and dc_gnt are never high together.
- Reset values, all applied asynchronously while rst=0:
  - State goes to IDLE.
  - mem_req, ic_gnt, dc_gnt, ic_done, dc_done, err and mem_addr are all 0.
  - The beat counter is 0 and last_grant is icache.
- Reset mid-transfer abandons the transaction; beats arriving after reset release are dropped in IDLE.
- err clears only on reset.

## Timing
- Request high in IDLE at edge N gives gnt, mem_req and mem_addr valid after edge N (one-cycle grant latency).
- mem_ack sampled at edge M: DATA from M, mem_req low after M. The earliest first beat is accepted at edge M+1.
- Last beat accepted at edge L gives xx_done high for the cycle after L.
- Earliest next grant is at the edge following the DONE cycle.
- Minimum overhead per line is 3 cycles plus BEATS_PER_LINE beat cycles.
- Beat forwarding adds zero latency: xx_beat_valid and beat_data appear in the same cycle as mem_beat_valid.
- mem_beat_valid or mem_last seen in IDLE, REQ or DONE is ignored and does not set err.

## Test plan
- Single icache miss:
  - Stimulus: ic_addr=0x8000_1234, ack immediately, 8 back-to-back beats 0..7, mem_last on beat 7.
  - Response: mem_addr=0x8000_1200; ic_beat_valid ×8 with beat_idx 0..7; ic_done 1 cycle; err=0.
- Simultaneous requests after reset:
  - First grant dc. After dc_done, with ic and dc both still high, the next grant is ic, then dc.
  - Check strict alternation over 6 lines and that the gnt signals are never both high.
- Wait states:
  - mem_ack delayed 5 cycles, then beats with random gaps.
  - mem_req is held constant until ack; the beat count is exactly 8; done comes 1 cycle after the 8th valid beat.
- Protocol errors:
  - mem_last on beat 4 gives DONE after beat 4 and err=1.
  - mem_last missing on beat 7 gives err=1.
  - err stays 1 through later clean transfers.
- Reset mid-DATA:
  - Pull rst low after beat 3, then release, then send stray beats.
  - All outputs are 0 at reset, stray beats produce no beat_valid, and state is IDLE.
- Request withdrawal:
  - ic_req drops during REQ.
  - The transfer still completes all 8 beats and ic_done pulses.
